// File: rtl/qlearn_pkg.sv
// Shared widths, Q4.4 constants, FSM encodings and LFSR taps for the
// tabular Q-learning step controller.
package qlearn_pkg;

  localparam int STATE_W = 6;
  localparam int ACT_W   = 2;
  localparam int ADDR_W  = STATE_W + ACT_W;
  localparam int DATA_W  = 8;

  localparam logic [7:0] ONE_Q44   = 8'h10;
  // x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3 when shifting left
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RDQ  = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_SUM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  function automatic logic [7:0] clamp_one(input logic [7:0] v);
    return (v > ONE_Q44) ? ONE_Q44 : v;
  endfunction

endpackage

// File: rtl/qlearn_update_dp.sv
// Q-update arithmetic: (1-a)*q + a*r + (a*g)*Qmax(s'), products in MUL,
// Q14.12 sum in SUM, truncate/saturate back to Q4.4 for write-back.
module qlearn_update_dp
  import qlearn_pkg::*;
#(
  parameter int DATA_W = qlearn_pkg::DATA_W
) (
  input  logic                  i_clk,
  input  logic                  i_mul_en,
  input  logic                  i_sum_en,
  input  logic [DATA_W-1:0]     i_alpha,
  input  logic [2*DATA_W-1:0]   i_ag,
  input  logic [DATA_W-1:0]     i_q,
  input  logic [DATA_W-1:0]     i_r,
  input  logic [DATA_W-1:0]     i_qmaxn,
  output logic [DATA_W-1:0]     o_q_new
);

  localparam int FRAC_W = DATA_W / 2;
  localparam int SUM_W  = 3 * DATA_W + 2;
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1) << FRAC_W;

  logic [DATA_W-1:0]   w_one_m_a;
  logic [2*DATA_W-1:0] r_prod_q_p0;
  logic [2*DATA_W-1:0] r_prod_r_p0;
  logic [3*DATA_W-1:0] r_prod_g_p0;
  logic [SUM_W-1:0]    r_sum_p1;

  function automatic logic [DATA_W-1:0] sat_q(input logic [SUM_W-1:0] s);
    return (|s[SUM_W-1:2*DATA_W]) ? '1 : s[2*DATA_W-1:DATA_W];
  endfunction

  assign w_one_m_a = ONE - i_alpha;

  // MUL stage: all three products from the freshly read BRAM data
  always_ff @(posedge i_clk) begin
    if (i_mul_en) begin
      r_prod_q_p0 <= {{DATA_W{1'b0}}, w_one_m_a} * {{DATA_W{1'b0}}, i_q};
      r_prod_r_p0 <= {{DATA_W{1'b0}}, i_alpha} * {{DATA_W{1'b0}}, i_r};
      r_prod_g_p0 <= {{DATA_W{1'b0}}, i_ag} * {{(2*DATA_W){1'b0}}, i_qmaxn};
    end
  end

  // SUM stage: align the Q8.8 products with the Q12.12 discount term
  always_ff @(posedge i_clk) begin
    if (i_sum_en) begin
      r_sum_p1 <= ({{(SUM_W-2*DATA_W){1'b0}}, r_prod_q_p0} << FRAC_W)
                + ({{(SUM_W-2*DATA_W){1'b0}}, r_prod_r_p0} << FRAC_W)
                + {{(SUM_W-3*DATA_W){1'b0}}, r_prod_g_p0};
    end
  end

  assign o_q_new = sat_q(r_sum_p1);

endmodule

// File: rtl/qlearn_step_ctrl.sv
// Episode sequencer for tabular Q-learning: 4-cycle steps RDQ/MUL/SUM/WB
// driving single-port Q/Qmax BRAMs and the reward/next-state ROMs.
module qlearn_step_ctrl
  import qlearn_pkg::*;
#(
  parameter int         STATE_W   = qlearn_pkg::STATE_W,
  parameter int         ACT_W     = qlearn_pkg::ACT_W,
  parameter int         ADDR_W    = qlearn_pkg::ADDR_W,
  parameter int         DATA_W    = qlearn_pkg::DATA_W,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [DATA_W-1:0]  i_alpha,
  input  logic [DATA_W-1:0]  i_gamma,
  input  logic [STATE_W-1:0] i_start_state,
  input  logic [STATE_W-1:0] i_end_state,
  input  logic [15:0]        i_max_steps,
  output logic [ADDR_W-1:0]  o_q_addr,
  output logic               o_q_we,
  output logic [DATA_W-1:0]  o_q_wdata,
  input  logic [DATA_W-1:0]  i_q_rdata,
  output logic [STATE_W-1:0] o_qmax_addr,
  output logic               o_qmax_we,
  output logic [DATA_W-1:0]  o_qmax_wdata,
  input  logic [DATA_W-1:0]  i_qmax_rdata,
  output logic [ADDR_W-1:0]  o_rn_addr,
  input  logic [DATA_W-1:0]  i_r_data,
  input  logic [STATE_W-1:0] i_ns_data,
  output logic               o_busy,
  output logic               o_done,
  output logic [STATE_W-1:0] o_state,
  output logic [15:0]        o_steps
);

  logic [2:0]           r_fsm;
  logic [7:0]           r_lfsr;
  logic [STATE_W-1:0]   r_s;
  logic [15:0]          r_steps;
  logic [DATA_W-1:0]    r_alpha;
  logic [2*DATA_W-1:0]  r_ag;
  logic [STATE_W-1:0]   r_end;
  logic [15:0]          r_max;
  logic [ACT_W-1:0]     r_act;
  logic [DATA_W-1:0]    r_r;
  logic [STATE_W-1:0]   r_ns;
  logic [DATA_W-1:0]    r_qmaxs;

  logic [DATA_W-1:0]    w_alpha_cl;
  logic [DATA_W-1:0]    w_gamma_cl;
  logic [DATA_W-1:0]    w_q_new;
  logic [16:0]          w_steps_inc;
  logic                 w_last;
  logic                 w_qmax_up;
  logic                 w_start_ok;

  assign w_alpha_cl  = clamp_one(i_alpha);
  assign w_gamma_cl  = clamp_one(i_gamma);
  assign w_start_ok  = (r_fsm == S_IDLE) && i_start;
  assign w_steps_inc = {1'b0, r_steps} + 17'd1;
  assign w_last      = (r_ns == r_end) ||
                       ((r_max != 16'd0) && (w_steps_inc == {1'b0, r_max}));
  assign w_qmax_up   = (w_q_new > r_qmaxs);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fsm   <= S_IDLE;
      r_lfsr  <= LFSR_SEED;
      r_s     <= '0;
      r_steps <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: if (i_start) begin
          r_s     <= i_start_state;
          r_steps <= '0;
          r_fsm   <= S_RDQ;
        end
        S_RDQ: begin
          r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
          r_fsm  <= S_MUL;
        end
        S_MUL: r_fsm <= S_SUM;
        S_SUM: r_fsm <= S_WB;
        S_WB: begin
          r_s <= r_ns;
          if (r_steps != 16'hFFFF) r_steps <= w_steps_inc[15:0];
          r_fsm <= w_last ? S_DONE : S_RDQ;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  // Episode parameters and per-step operands need no reset: every use is gated by the FSM
  always_ff @(posedge i_clk) begin
    if (w_start_ok) begin
      r_alpha <= w_alpha_cl;
      r_ag    <= {{DATA_W{1'b0}}, w_alpha_cl} * {{DATA_W{1'b0}}, w_gamma_cl};
      r_end   <= i_end_state;
      r_max   <= i_max_steps;
    end
    if (r_fsm == S_RDQ) begin
      r_act <= r_lfsr[ACT_W-1:0];
      r_r   <= i_r_data;
      r_ns  <= i_ns_data;
    end
    if (r_fsm == S_SUM) r_qmaxs <= i_qmax_rdata;
  end

  qlearn_update_dp #(.DATA_W(DATA_W)) u_dp (
    .i_clk    (i_clk),
    .i_mul_en (r_fsm == S_MUL),
    .i_sum_en (r_fsm == S_SUM),
    .i_alpha  (r_alpha),
    .i_ag     (r_ag),
    .i_q      (i_q_rdata),
    .i_r      (r_r),
    .i_qmaxn  (i_qmax_rdata),
    .o_q_new  (w_q_new)
  );

  always_comb begin
    o_q_addr     = '0;
    o_q_we       = 1'b0;
    o_q_wdata    = '0;
    o_qmax_addr  = '0;
    o_qmax_we    = 1'b0;
    o_qmax_wdata = '0;
    o_rn_addr    = '0;
    case (r_fsm)
      S_RDQ: begin
        o_q_addr    = {r_s, r_lfsr[ACT_W-1:0]};
        o_rn_addr   = {r_s, r_lfsr[ACT_W-1:0]};
        o_qmax_addr = i_ns_data;
      end
      S_MUL: o_qmax_addr = r_s;
      S_WB: begin
        o_q_addr  = {r_s, r_act};
        o_q_we    = 1'b1;
        o_q_wdata = w_q_new;
        if (w_qmax_up) begin
          o_qmax_addr  = r_s;
          o_qmax_we    = 1'b1;
          o_qmax_wdata = w_q_new;
        end
      end
      default: ;
    endcase
  end

  assign o_busy  = (r_fsm == S_RDQ) || (r_fsm == S_MUL) ||
                   (r_fsm == S_SUM) || (r_fsm == S_WB);
  assign o_done  = (r_fsm == S_DONE);
  assign o_state = r_s;
  assign o_steps = r_steps;

endmodule

// File: tb/tb_qlearn_step_ctrl.sv
// Directed bench for qlearn_step_ctrl with behavioural Q/Qmax BRAMs and
// reward/next-state ROMs; expected values are hand-computed Q4.4 results.
module tb_qlearn_step_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  alpha = '0, gamma = '0;
  logic [5:0]  sst = '0, est = '0;
  logic [15:0] maxs = '0;
  logic [7:0]  q_addr, q_wdata, q_rd, qm_wdata, qm_rd, r_data, rn_addr;
  logic        q_we, qm_we, busy, done;
  logic [5:0]  qm_addr, ns_data, state;
  logic [15:0] steps;

  always #5 clk = ~clk;

  qlearn_step_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_alpha(alpha), .i_gamma(gamma), .i_start_state(sst), .i_end_state(est),
    .i_max_steps(maxs),
    .o_q_addr(q_addr), .o_q_we(q_we), .o_q_wdata(q_wdata), .i_q_rdata(q_rd),
    .o_qmax_addr(qm_addr), .o_qmax_we(qm_we), .o_qmax_wdata(qm_wdata),
    .i_qmax_rdata(qm_rd),
    .o_rn_addr(rn_addr), .i_r_data(r_data), .i_ns_data(ns_data),
    .o_busy(busy), .o_done(done), .o_state(state), .o_steps(steps)
  );

  // Table models: host ports preload the BRAMs while the controller is idle
  logic [7:0] q_mem [256];
  logic [7:0] qm_mem [64];
  logic [7:0] r_rom [256];
  logic [5:0] ns_rom [256];
  logic       h_q_we = 1'b0, h_qm_we = 1'b0;
  logic [7:0] h_q_addr = '0, h_data = '0;
  logic [5:0] h_qm_addr = '0;

  always @(posedge clk) begin
    if (h_q_we) q_mem[h_q_addr] <= h_data;
    else if (q_we) q_mem[q_addr] <= q_wdata;
    if (h_qm_we) qm_mem[h_qm_addr] <= h_data;
    else if (qm_we) qm_mem[qm_addr] <= qm_wdata;
    q_rd  <= q_mem[q_addr];
    qm_rd <= qm_mem[qm_addr];
  end
  assign r_data  = r_rom[rn_addr];
  assign ns_data = ns_rom[rn_addr];

  int cyc = 0;
  int q_wr_cnt = 0, qm_wr_cnt = 0, done_cnt = 0, done_cyc = 0;
  int q_wr_cyc [64];
  logic [7:0] q_wr_data = '0, q_wr_addr = '0, qm_wr_data = '0;
  logic [5:0] qm_wr_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (q_we) begin
      q_wr_cyc[q_wr_cnt % 64] <= cyc;
      q_wr_cnt  <= q_wr_cnt + 1;
      q_wr_data <= q_wdata;
      q_wr_addr <= q_addr;
    end
    if (qm_we) begin
      qm_wr_cnt  <= qm_wr_cnt + 1;
      qm_wr_data <= qm_wdata;
      qm_wr_addr <= qm_addr;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  int n_chk = 0, n_err = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] lfsr_m = 8'hA5;
  function automatic logic [7:0] lfsr_nx(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic set_q(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); h_q_we = 1'b1; h_q_addr = a; h_data = d;
    @(negedge clk); h_q_we = 1'b0;
  endtask

  task automatic set_qm(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk); h_qm_we = 1'b1; h_qm_addr = a; h_data = d;
    @(negedge clk); h_qm_we = 1'b0;
  endtask

  // Same reward/next-state/Q for all four actions of state s
  task automatic set_state(input logic [5:0] s, input logic [7:0] r,
                           input logic [5:0] ns, input logic [7:0] q);
    for (int a = 0; a < 4; a++) begin
      r_rom[{s, 2'(a)}]  = r;
      ns_rom[{s, 2'(a)}] = ns;
      set_q({s, 2'(a)}, q);
    end
  endtask

  int rdq_cyc, q0, qm0, d0;
  task automatic start_ep(input logic [7:0] al, input logic [7:0] ga,
                          input logic [5:0] st, input logic [5:0] en,
                          input logic [15:0] mx);
    @(negedge clk);
    q0 = q_wr_cnt; qm0 = qm_wr_cnt; d0 = done_cnt;
    alpha = al; gamma = ga; sst = st; est = en; maxs = mx; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rdq_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == d0) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  logic [1:0] a_exp;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q_we", q_we, 0);
    check("rst_qm_we", qm_we, 0);
    check("rst_state", state, 0);
    check("rst_steps", steps, 0);
    check("rst_q_addr", q_addr, 0);
    rst_n = 1'b1;

    // reset during SUM discards the step
    set_state(6'd1, 8'h20, 6'd2, 8'h10);
    start_ep(8'h08, 8'h08, 6'd1, 6'd2, 16'd0);
    check("mid_busy_rdq", busy, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_q_we", q_we, 0);
    check("mid_rst_state", state, 0);
    check("mid_rst_qaddr", q_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_no_qwrite", q_wr_cnt - q0, 0);
    check("mid_no_done", done_cnt - d0, 0);
    lfsr_m = 8'hA5;

    // single step: 0.5*1 + 0.5*2 + 0.25*4 = 2.5
    set_state(6'd5, 8'h20, 6'd6, 8'h10);
    set_qm(6'd6, 8'h40);
    set_qm(6'd5, 8'h00);
    a_exp = lfsr_m[1:0]; lfsr_m = lfsr_nx(lfsr_m);
    start_ep(8'h08, 8'h08, 6'd5, 6'd6, 16'd0);
    wait_done(50);
    check("one_qw_cnt", q_wr_cnt - q0, 1);
    check("one_q_data", q_wr_data, 8'h28);
    check("one_q_addr", q_wr_addr, {6'd5, a_exp});
    check("one_q_cyc", q_wr_cyc[q0 % 64], rdq_cyc + 3);
    check("one_qm_cnt", qm_wr_cnt - qm0, 1);
    check("one_qm_data", qm_wr_data, 8'h28);
    check("one_qm_addr", qm_wr_addr, 6'd5);
    check("one_done_cyc", done_cyc, rdq_cyc + 4);
    check("one_done_cnt", done_cnt - d0, 1);
    check("one_steps", steps, 1);
    check("one_state", state, 6'd6);
    check("one_busy", busy, 0);

    // saturation: 1*0xFF + 1*0xFF overflows Q4.4
    set_state(6'd7, 8'hFF, 6'd8, 8'h33);
    set_qm(6'd8, 8'hFF);
    set_qm(6'd7, 8'h00);
    a_exp = lfsr_m[1:0]; lfsr_m = lfsr_nx(lfsr_m);
    start_ep(8'h10, 8'h10, 6'd7, 6'd8, 16'd0);
    wait_done(50);
    check("sat_q_data", q_wr_data, 8'hFF);
    check("sat_q_addr", q_wr_addr, {6'd7, a_exp});
    check("sat_qm_data", qm_wr_data, 8'hFF);

    // alpha clamp: 0x30 acts as 1.0 -> r + Qmax(s') = 3.0 + 1.5
    set_state(6'd9, 8'h30, 6'd10, 8'h20);
    set_qm(6'd10, 8'h18);
    set_qm(6'd9, 8'h00);
    lfsr_m = lfsr_nx(lfsr_m);
    start_ep(8'h30, 8'h10, 6'd9, 6'd10, 16'd0);
    wait_done(50);
    check("clamp_a_data", q_wr_data, 8'h48);
    // gamma clamp on the same tables; Qmax(9) is already 0x48, so no Qmax write
    lfsr_m = lfsr_nx(lfsr_m);
    start_ep(8'h10, 8'hFF, 6'd9, 6'd10, 16'd0);
    wait_done(50);
    check("clamp_g_data", q_wr_data, 8'h48);
    check("clamp_g_qm_cnt", qm_wr_cnt - qm0, 0);

    // Qmax(s) above q_new is not lowered
    set_state(6'd11, 8'h20, 6'd12, 8'h10);
    set_qm(6'd12, 8'h40);
    set_qm(6'd11, 8'h50);
    lfsr_m = lfsr_nx(lfsr_m);
    start_ep(8'h08, 8'h08, 6'd11, 6'd12, 16'd0);
    wait_done(50);
    check("nolow_q_data", q_wr_data, 8'h28);
    check("nolow_qm_cnt", qm_wr_cnt - qm0, 0);

    // step limit 5 on a chain 20->21->..., terminal state unreachable
    for (int s = 20; s < 30; s++) begin
      set_state(6'(s), 8'h10, 6'(s + 1), 8'h00);
      set_qm(6'(s), 8'h00);
    end
    set_qm(6'd30, 8'h00);
    for (int k = 0; k < 5; k++) begin
      a_exp = lfsr_m[1:0];
      lfsr_m = lfsr_nx(lfsr_m);
    end
    start_ep(8'h08, 8'h00, 6'd20, 6'd63, 16'd5);
    repeat (5) @(negedge clk);
    sst = 6'd40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("lim_busy_mid", busy, 1);
    wait_done(100);
    check("lim_qw_cnt", q_wr_cnt - q0, 5);
    for (int k = 0; k < 5; k++)
      check($sformatf("lim_q_cyc%0d", k), q_wr_cyc[(q0 + k) % 64], rdq_cyc + 3 + 4 * k);
    check("lim_q_data", q_wr_data, 8'h08);
    check("lim_q_addr", q_wr_addr, {6'd24, a_exp});
    check("lim_qm_cnt", qm_wr_cnt - qm0, 5);
    check("lim_qm_addr", qm_wr_addr, 6'd24);
    check("lim_steps", steps, 5);
    check("lim_state", state, 6'd25);
    check("lim_done_cnt", done_cnt - d0, 1);
    check("lim_done_cyc", done_cyc, rdq_cyc + 20);
    repeat (4) @(negedge clk);
    check("lim_idle", busy, 0);
    check("lim_no_restart", q_wr_cnt - q0, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
